// File: rtl/ntt_params.sv
// Shared NTT parameters: residue width, modulus index width, ROM depth.
// Also holds the stage bundle used between the adder's pipeline registers.
package ntt_params;

  localparam int WIDTH     = 30;
  localparam int IDX_W     = 4;
  localparam int ROM_DEPTH = 16;

  typedef logic [WIDTH-1:0] res_t;
  typedef logic [WIDTH:0]   sum_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    sum_t sum;
    res_t q;
  } s1_t;

endpackage

// File: rtl/prime_rom.sv
// Prime ROM: 16 NTT-friendly primes below 2^30, combinational read.
module prime_rom
  import ntt_params::*;
(
  input  logic [IDX_W-1:0] a,
  output logic [WIDTH-1:0] spo
);

  always_comb begin
    spo = '0;
    case (a)
      4'd0:  spo = 30'd998244353;
      4'd1:  spo = 30'd469762049;
      4'd2:  spo = 30'd167772161;
      4'd3:  spo = 30'd754974721;
      4'd4:  spo = 30'd1004535809;
      4'd5:  spo = 30'd985661441;
      4'd6:  spo = 30'd943718401;
      4'd7:  spo = 30'd962592769;
      4'd8:  spo = 30'd950009857;
      4'd9:  spo = 30'd924844033;
      4'd10: spo = 30'd1045430273;
      4'd11: spo = 30'd1051721729;
      4'd12: spo = 30'd1053818881;
      4'd13: spo = 30'd897581057;
      4'd14: spo = 30'd880803841;
      4'd15: spo = 30'd113246209;
      default: spo = '0;
    endcase
  end

endmodule

// File: rtl/modular_adder_pipe.sv
// Two-stage pipelined (a + b) mod q with valid/ready and backpressure.
// q is captured per transaction so index changes never touch accepted pairs.
module modular_adder_pipe
  import ntt_params::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mod_sel,
  input  logic [IDX_W-1:0] mod_index,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c
);

  idx_t r_idx;
  res_t w_q;
  s1_t  r_s1;
  logic r_s1_valid;
  logic r_out_valid;
  res_t r_c;

  logic w_s2_load;
  logic w_s1_adv;
  logic w_s1_load;
  logic w_in_xfer;
  res_t w_red;

  function automatic res_t mod_red(input sum_t s, input res_t q);
    logic signed [31:0] d;
    d = $signed({1'b0, s}) - $signed({2'b00, q});
    return d[31] ? s[WIDTH-1:0] : d[WIDTH-1:0];
  endfunction

  prime_rom u_rom (
    .a   (r_idx),
    .spo (w_q)
  );

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign w_s1_load = !r_s1_valid || w_s1_adv;
  assign w_in_xfer = in_valid && w_s1_load;
  assign w_red     = mod_red(r_s1.sum, r_s1.q);

  assign in_ready  = w_s1_load;
  assign out_valid = r_out_valid;
  assign c         = r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (mod_sel) begin
      r_idx <= mod_index;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_xfer) begin
        r_s1.sum <= {1'b0, a} + {1'b0, b};
        r_s1.q   <= w_q;
      end
    end
  end

  // Output register: holds c steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_c         <= '0;
    end else begin
      if (w_s2_load) begin
        r_out_valid <= r_s1_valid;
      end
      if (w_s1_adv) begin
        r_c <= w_red;
      end
    end
  end

endmodule

// File: tb/tb_modular_adder_pipe.sv
// Directed and random checks of modular_adder_pipe against a
// (a+b)%q scoreboard with an independent copy of the ROM contents.
module tb_modular_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mod_sel;
  logic [3:0]  mod_index;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] a;
  logic [29:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [29:0] c;

  int n_chk = 0;
  int n_fail = 0;

  logic [29:0] qtab [16];
  logic [29:0] sb [$];
  logic [3:0]  idx_m;
  logic        prev_stall;
  logic [29:0] prev_c;
  logic [29:0] q0;
  logic [29:0] q3;
  int          acc_cnt;

  always #5 clk = ~clk;

  modular_adder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mod_sel   (mod_sel),
    .mod_index (mod_index),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] model(input logic [29:0] x,
                                        input logic [29:0] y,
                                        input logic [29:0] q);
    longint unsigned s;
    s = longint'(x) + longint'(y);
    return 30'(s % longint'(q));
  endfunction

  task automatic tick();
    logic [29:0] e;
    #1;
    if (prev_stall) begin
      check("hold_ov", {31'd0, out_valid}, 32'd1);
      check("hold_c", {2'b0, c}, {2'b0, prev_c});
    end
    if (in_valid && in_ready)
      sb.push_back(model(a, b, qtab[idx_m]));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_c", {2'b0, c}, {2'b0, e});
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_c = c;
    if (mod_sel) idx_m = mod_index;
    @(posedge clk);
    #1;
  endtask

  initial begin
    qtab = '{30'd998244353, 30'd469762049, 30'd167772161, 30'd754974721,
             30'd1004535809, 30'd985661441, 30'd943718401, 30'd962592769,
             30'd950009857, 30'd924844033, 30'd1045430273, 30'd1051721729,
             30'd1053818881, 30'd897581057, 30'd880803841, 30'd113246209};
    q0 = qtab[0];
    q3 = qtab[3];
    idx_m = 4'd0;
    prev_stall = 1'b0;
    prev_c = '0;
    rst_n = 1'b0;
    mod_sel = 1'b0;
    mod_index = 4'd0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_c", {2'b0, c}, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic sums, q0
    in_valid = 1'b1; a = 30'd5; b = 30'd7;
    tick();
    in_valid = 1'b0;
    check("lat_ov0", {31'd0, out_valid}, 32'd0);
    tick();
    check("b57_ov", {31'd0, out_valid}, 32'd1);
    check("b57_c", {2'b0, c}, 32'd12);
    in_valid = 1'b1; a = q0 - 30'd1; b = 30'd1;
    tick();
    in_valid = 1'b0;
    tick();
    check("wrap0_c", {2'b0, c}, 32'd0);
    in_valid = 1'b1; a = q0 - 30'd1; b = q0 - 30'd1;
    tick();
    in_valid = 1'b0;
    tick();
    check("max_c", {2'b0, c}, {2'b0, q0 - 30'd2});
    tick();

    // streaming
    for (int i = 0; i < 102; i++) begin
      in_valid = (i < 100);
      a = 30'($urandom_range(q0 - 1, 0));
      b = 30'($urandom_range(q0 - 1, 0));
      #1;
      check("strm_rdy", {31'd0, in_ready}, 32'd1);
      if (i >= 2) check("strm_ov", {31'd0, out_valid}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("strm_empty", sb.size(), 32'd0);

    // backpressure
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      a = 30'(i * 100);
      b = q0 - 30'd50;
      #1;
      if (in_ready) acc_cnt++;
      tick();
    end
    check("bp_acc", acc_cnt, 32'd2);
    check("bp_rdy", {31'd0, in_ready}, 32'd0);
    check("bp_ov", {31'd0, out_valid}, 32'd1);
    check("bp_c", {2'b0, c}, 32'd50);
    out_ready = 1'b1;
    a = 30'd9; b = 30'd9;
    #1;
    check("bp_resume_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_c2", {2'b0, c}, 32'd150);
    in_valid = 1'b0;
    repeat (3) tick();
    check("bp_empty", sb.size(), 32'd0);

    // modulus switch mid-stream
    in_valid = 1'b1; mod_sel = 1'b1; mod_index = 4'd3;
    a = q0 - 30'd1; b = 30'd2;
    tick();
    mod_sel = 1'b0;
    a = q3 - 30'd1; b = 30'd5;
    tick();
    in_valid = 1'b0;
    check("msw_p1", {2'b0, c}, 32'd1);
    tick();
    check("msw_p2", {2'b0, c}, 32'd4);
    tick();

    // async reset with both stages full
    out_ready = 1'b0; in_valid = 1'b1;
    a = 30'd1; b = 30'd2;
    tick();
    a = 30'd3; b = 30'd4;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ov", {31'd0, out_valid}, 32'd0);
    check("ar_c", {2'b0, c}, 32'd0);
    check("ar_rdy", {31'd0, in_ready}, 32'd1);
    sb.delete();
    idx_m = 4'd0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ar_nostale", {31'd0, out_valid}, 32'd0);
    check("ar_rdy2", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; a = q0 - 30'd1; b = 30'd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("ar_idx0", {2'b0, c}, 32'd2);
    tick();

    // random valid/ready/index toggling
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(1, 0));
      out_ready = ($urandom_range(3, 0) != 0);
      mod_sel = ($urandom_range(15, 0) == 0);
      mod_index = 4'($urandom_range(15, 0));
      a = 30'($urandom_range(qtab[idx_m] - 1, 0));
      b = 30'($urandom_range(qtab[idx_m] - 1, 0));
      tick();
    end
    in_valid = 1'b0; mod_sel = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    check("rnd_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
